// File: rtl/roi_pkg.sv
// Shared types and constants for the ROI output stage.
// ROI_OUT_EOL_EN adds a stored end-of-line flag to each FIFO entry.
package roi_pkg;

    localparam int unsigned X_MSB      = 26;
    localparam int unsigned X_LSB      = 16;
    localparam int unsigned Y_MSB      = 9;
    localparam int unsigned Y_LSB      = 0;
    localparam int unsigned X_W        = X_MSB - X_LSB + 1;
    localparam int unsigned Y_W        = Y_MSB - Y_LSB + 1;
    localparam int unsigned WIDTH_DEF  = 800;
    localparam int unsigned HEIGHT_DEF = 600;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } wr_state_t;

    // Marker bits carried alongside each pixel in the FIFO
    typedef struct packed {
        logic sof;
`ifdef ROI_OUT_EOL_EN
        logic eol;
`endif
        logic eof;
    } roi_flags_t;

    localparam int unsigned FLAG_W = $bits(roi_flags_t);

    function automatic logic [X_W-1:0] span_x(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
        return ((a >= b) ? (a - b) : (b - a)) + X_W'(1);
    endfunction

    function automatic logic [Y_W-1:0] span_y(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
        return ((a >= b) ? (a - b) : (b - a)) + Y_W'(1);
    endfunction

endpackage

// File: rtl/roi_axis_out_if.sv
// AXI4-Stream master bus presented by the ROI output stage.
interface roi_axis_out_if #(
    parameter int unsigned BIT_DATA = 8
);
    logic [BIT_DATA-1:0] m_tdata_o;
    logic                m_tvalid_o;
    logic                m_tready_i;
    logic                m_tuser_o;
    logic                m_tlast_o;

    modport master (
        output m_tdata_o,
        output m_tvalid_o,
        output m_tuser_o,
        output m_tlast_o,
        input  m_tready_i
    );

    modport slave (
        input  m_tdata_o,
        input  m_tvalid_o,
        input  m_tuser_o,
        input  m_tlast_o,
        output m_tready_i
    );
endinterface

// File: rtl/roi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty/level.
module roi_sync_fifo #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       r_level;
    logic              r_full;
    logic              r_empty;
    logic [AW:0]       w_wr_ptr_n;
    logic [AW:0]       w_rd_ptr_n;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] r_mem [DEPTH];

    // A push into a full FIFO is dropped even if a pop happens in the same cycle
    assign w_push     = i_push && !r_full;
    assign w_pop      = i_pop && !r_empty;
    assign w_wr_ptr_n = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_ptr_n = r_rd_ptr + (AW+1)'(w_pop);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_n;
            r_rd_ptr <= w_rd_ptr_n;
            r_level  <= w_wr_ptr_n - w_rd_ptr_n;
            r_full   <= (w_wr_ptr_n[AW] != w_rd_ptr_n[AW]) &&
                        (w_wr_ptr_n[AW-1:0] == w_rd_ptr_n[AW-1:0]);
            r_empty  <= (w_wr_ptr_n == w_rd_ptr_n);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Head word is forced to zero while empty so the bus idles at 0
    assign o_data  = r_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_level = r_level;

endmodule

// File: rtl/roi_axis_out.sv
// ROI crop output stage: regenerates SOF/line/frame markers and buffers into AXI4-Stream.
// Define ROI_OUT_EOL_EN to drive m_tlast_o on every line end instead of frame end only.
module roi_axis_out
    import roi_pkg::*;
#(
    parameter int unsigned BIT_DATA  = 8,
    parameter int unsigned BIT_COORD = 32,
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned HEIGHT    = HEIGHT_DEF,
    parameter int unsigned DEPTH     = 64
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic [BIT_DATA-1:0]      s_tdata_i,
    input  logic                     s_tvalid_i,
    input  logic                     s_tlast_i,
    input  logic [BIT_COORD-1:0]     xy_0_i,
    input  logic [BIT_COORD-1:0]     xy_1_i,
    input  logic                     clr_ovf_i,
    roi_axis_out_if.master           m_axis,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned ENTRY_W = BIT_DATA + FLAG_W;

    logic [X_W-1:0]     w_x0, w_x1, w_geom_w, w_cur_w;
    logic [Y_W-1:0]     w_y0, w_y1, w_geom_h, w_cur_h;
    logic               w_geom_ok;
    logic               w_unused_xy;

    wr_state_t          r_state, w_state_n;
    logic [X_W-1:0]     r_col, w_col_n, r_w, w_w_n;
    logic [Y_W-1:0]     r_row, w_row_n, r_h, w_h_n;
    logic               w_accept, w_eol, w_eof, w_last_col;
    roi_flags_t         w_flags;

    logic               r_stg_vld;
    logic [ENTRY_W-1:0] r_stg_entry;
    logic               r_ovf;

    logic [ENTRY_W-1:0] w_rd_entry;
    roi_flags_t         w_rd_flags;
    logic               w_full, w_empty;

    assign w_x0 = xy_0_i[X_MSB:X_LSB];
    assign w_x1 = xy_1_i[X_MSB:X_LSB];
    assign w_y0 = xy_0_i[Y_MSB:Y_LSB];
    assign w_y1 = xy_1_i[Y_MSB:Y_LSB];
    assign w_unused_xy = ^{xy_0_i[BIT_COORD-1:X_MSB+1], xy_0_i[X_LSB-1:Y_MSB+1],
                           xy_1_i[BIT_COORD-1:X_MSB+1], xy_1_i[X_LSB-1:Y_MSB+1]};

    assign w_geom_w  = span_x(w_x0, w_x1);
    assign w_geom_h  = span_y(w_y0, w_y1);
    assign w_geom_ok = (w_x0 <= X_W'(WIDTH))  && (w_x1 <= X_W'(WIDTH)) &&
                       (w_y0 <= Y_W'(HEIGHT)) && (w_y1 <= Y_W'(HEIGHT));

    // Write-side FSM; in IDLE the live geometry is used since it latches on this pixel
    always_comb begin
        w_state_n  = r_state;
        w_col_n    = r_col;
        w_row_n    = r_row;
        w_w_n      = r_w;
        w_h_n      = r_h;
        w_cur_w    = r_w;
        w_cur_h    = r_h;
        w_accept   = 1'b0;
        w_eol      = 1'b0;
        w_eof      = 1'b0;
        w_last_col = 1'b0;
        w_flags    = '0;

        case (r_state)
            IDLE: begin
                w_cur_w = w_geom_w;
                w_cur_h = w_geom_h;
                if (s_tvalid_i && w_geom_ok) begin
                    w_accept    = 1'b1;
                    w_w_n       = w_geom_w;
                    w_h_n       = w_geom_h;
                    w_flags.sof = 1'b1;
                end
            end
            ACTIVE: begin
                w_accept = s_tvalid_i;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase

        if (w_accept) begin
            w_last_col = (r_col == w_cur_w - X_W'(1));
            w_eol      = w_last_col || s_tlast_i;
            w_eof      = (w_last_col && (r_row == w_cur_h - Y_W'(1))) || s_tlast_i;
            if (w_eof) begin
                w_col_n   = '0;
                w_row_n   = '0;
                w_state_n = IDLE;
            end else if (w_eol) begin
                w_col_n   = '0;
                w_row_n   = r_row + Y_W'(1);
                w_state_n = ACTIVE;
            end else begin
                w_col_n   = r_col + X_W'(1);
                w_state_n = ACTIVE;
            end
        end

        w_flags.eof = w_eof;
`ifdef ROI_OUT_EOL_EN
        w_flags.eol = w_eol;
`endif
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_stg_vld   <= 1'b0;
            r_stg_entry <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_col     <= w_col_n;
            r_row     <= w_row_n;
            r_w       <= w_w_n;
            r_h       <= w_h_n;
            r_stg_vld <= w_accept;
            if (w_accept) begin
                r_stg_entry <= {s_tdata_i, w_flags};
            end
            // Set wins over clear when a drop coincides with clr_ovf_i
            if (r_stg_vld && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    roi_sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .i_push  (r_stg_vld),
        .i_data  (r_stg_entry),
        .i_pop   (m_axis.m_tready_i),
        .o_data  (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level_o)
    );

    assign w_rd_flags        = roi_flags_t'(w_rd_entry[FLAG_W-1:0]);
    assign m_axis.m_tdata_o  = w_rd_entry[ENTRY_W-1:FLAG_W];
    assign m_axis.m_tvalid_o = !w_empty;
    assign m_axis.m_tuser_o  = w_rd_flags.sof;
`ifdef ROI_OUT_EOL_EN
    assign m_axis.m_tlast_o  = w_rd_flags.eol;
`else
    assign m_axis.m_tlast_o  = w_rd_flags.eof;
`endif
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_roi_axis_out.sv
// Scoreboard bench for roi_axis_out: directed frames, overflow, resync and reset cases.
module tb_roi_axis_out;

    localparam int unsigned BIT_DATA = 8;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned LVL_W    = $clog2(DEPTH) + 1;
`ifdef ROI_OUT_EOL_EN
    localparam bit EOL_EN = 1'b1;
`else
    localparam bit EOL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [BIT_DATA-1:0] data;
        logic                user;
        logic                last;
    } exp_t;

    logic                clk_i = 1'b0;
    logic                arst_i;
    logic [BIT_DATA-1:0] s_tdata;
    logic                s_tvalid;
    logic                s_tlast;
    logic [31:0]         xy_0;
    logic [31:0]         xy_1;
    logic                clr_ovf;
    logic                overflow;
    logic [LVL_W-1:0]    level;

    exp_t                q[$];
    int                  checks = 0;
    int                  errors = 0;
    logic [BIT_DATA-1:0] pix_cnt = '0;
    bit                  rnd_ready = 1'b0;
    bit                  stall = 1'b0;
    exp_t                held;

    always #5 clk_i = ~clk_i;

    roi_axis_out_if #(.BIT_DATA(BIT_DATA)) m_axis ();

    roi_axis_out #(
        .BIT_DATA  (BIT_DATA),
        .BIT_COORD (32),
        .WIDTH     (800),
        .HEIGHT    (600),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .s_tdata_i  (s_tdata),
        .s_tvalid_i (s_tvalid),
        .s_tlast_i  (s_tlast),
        .xy_0_i     (xy_0),
        .xy_1_i     (xy_1),
        .clr_ovf_i  (clr_ovf),
        .m_axis     (m_axis),
        .overflow_o (overflow),
        .level_o    (level)
    );

    function automatic logic [31:0] xy(input int x, input int y);
        logic [31:0] v;
        v        = '0;
        v[26:16] = 11'(x);
        v[9:0]   = 10'(y);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Sends n pixels of a WxH frame starting at frame index idx0; first keep are expected out
    task automatic send_frame(input int x0, input int y0, input int x1, input int y1,
                              input int w, input int h, input int idx0, input int n,
                              input int tl_at, input int keep, input int gap);
        xy_0 = xy(x0, y0);
        xy_1 = xy(x1, y1);
        for (int i = 0; i < n; i++) begin
            int   idx;
            bit   tl, eol, eof;
            exp_t e;
            idx    = idx0 + i;
            tl     = (i == tl_at);
            eol    = ((idx % w) == (w - 1)) || tl;
            eof    = (idx == (w * h - 1)) || tl;
            e.data = pix_cnt;
            e.user = (idx == 0);
            e.last = EOL_EN ? eol : eof;
            if (i < keep) q.push_back(e);
            s_tdata  = pix_cnt;
            s_tvalid = 1'b1;
            s_tlast  = tl;
            tick();
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            pix_cnt  = pix_cnt + 8'd1;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (q.size() == 0) break;
            tick();
        end
        repeat (2) tick();
        check(name, q.size(), 0);
    endtask

    always @(posedge clk_i) begin
        #1;
        if (rnd_ready) m_axis.m_tready_i = 1'($urandom_range(0, 1));
    end

    // Monitor: pops on every handshake and checks head stability while stalled
    always @(negedge clk_i) begin
        exp_t got;
        got = {m_axis.m_tdata_o, m_axis.m_tuser_o, m_axis.m_tlast_o};
        if (arst_i) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                checks++;
                if (!m_axis.m_tvalid_o || got != held) begin
                    errors++;
                    $display("FAIL stall_hold actual=%h/%0d required=%h/1", got, m_axis.m_tvalid_o, held);
                end
            end
            if (m_axis.m_tvalid_o && m_axis.m_tready_i) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", got);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (got != e) begin
                        errors++;
                        $display("FAIL beat actual=data %h user %0d last %0d required=data %h user %0d last %0d",
                                 got.data, got.user, got.last, e.data, e.user, e.last);
                    end
                end
            end
            stall = m_axis.m_tvalid_o && !m_axis.m_tready_i;
            held  = got;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_i   = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        xy_0     = '0;
        xy_1     = '0;
        clr_ovf  = 1'b0;
        m_axis.m_tready_i = 1'b1;
        #12;
        check("rst_tvalid", int'(m_axis.m_tvalid_o), 0);
        check("rst_tdata",  int'(m_axis.m_tdata_o), 0);
        check("rst_tuser",  int'(m_axis.m_tuser_o), 0);
        check("rst_tlast",  int'(m_axis.m_tlast_o), 0);
        check("rst_ovf",    int'(overflow), 0);
        check("rst_level",  int'(level), 0);
        tick();
        arst_i = 1'b0;
        tick();

        // 4x2 ROI with gaps, then the same ROI with swapped corners
        send_frame(10, 20, 13, 21, 4, 2, 0, 8, -1, 8, 1);
        wait_drain("drain_4x2");
        send_frame(13, 21, 10, 20, 4, 2, 0, 8, -1, 8, 0);
        wait_drain("drain_4x2_swapped");

        // Corner outside the large frame: everything discarded
        send_frame(0, 0, 900, 3, 901, 4, 0, 3, -1, 0, 0);
        repeat (3) tick();
        check("invalid_level", int'(level), 0);
        check("invalid_ovf", int'(overflow), 0);

        // tlast on 5th pixel of 4x4, then a 2x1 ROI proves re-latched geometry
        send_frame(0, 0, 3, 3, 4, 4, 0, 5, 4, 5, 0);
        send_frame(100, 50, 101, 50, 2, 1, 0, 2, -1, 2, 0);
        wait_drain("drain_resync");

        // Overflow: 64 fit, the 65th is dropped
        m_axis.m_tready_i = 1'b0;
        send_frame(0, 0, 9, 9, 10, 10, 0, 64, -1, 64, 0);
        repeat (3) tick();
        check("full_level", int'(level), 64);
        check("full_no_ovf", int'(overflow), 0);
        send_frame(0, 0, 9, 9, 10, 10, 64, 6, -1, 0, 0);
        repeat (3) tick();
        check("ovf_level", int'(level), 64);
        check("ovf_set", int'(overflow), 1);
        m_axis.m_tready_i = 1'b1;
        wait_drain("drain_64");
        check("drained_level", int'(level), 0);
        check("ovf_sticky", int'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        tick();
        check("ovf_cleared", int'(overflow), 0);
        send_frame(0, 0, 9, 9, 10, 10, 70, 1, 0, 1, 0);
        wait_drain("drain_close");

        // Random 50% ready over three 7x5 frames
        rnd_ready = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(5, 5, 11, 9, 7, 5, 0, 35, -1, 35, 1);
        wait_drain("drain_random");
        rnd_ready = 1'b0;
        tick();
        m_axis.m_tready_i = 1'b1;
        wait_drain("drain_random_tail");
        check("random_no_ovf", int'(overflow), 0);

        // Asynchronous reset mid-frame with 10 entries buffered
        m_axis.m_tready_i = 1'b0;
        send_frame(5, 5, 11, 9, 7, 5, 0, 10, -1, 0, 0);
        repeat (3) tick();
        check("pre_reset_level", int'(level), 10);
        #1;
        arst_i = 1'b1;
        #1;
        check("mid_rst_tvalid", int'(m_axis.m_tvalid_o), 0);
        check("mid_rst_tdata",  int'(m_axis.m_tdata_o), 0);
        check("mid_rst_tuser",  int'(m_axis.m_tuser_o), 0);
        check("mid_rst_tlast",  int'(m_axis.m_tlast_o), 0);
        check("mid_rst_level",  int'(level), 0);
        tick();
        arst_i = 1'b0;
        m_axis.m_tready_i = 1'b1;
        tick();
        send_frame(200, 100, 201, 100, 2, 1, 0, 2, -1, 2, 0);
        wait_drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
